maxpool_ctrl: RTL and testbench

MAXPOOL_CTRL -- requirements
Module: maxpool_ctrl

---
 rtl/maxpool_ctrl.sv | 171 +++++++++++++++++
 tb/tb_maxpool_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool_ctrl.sv
// 2x2 stride-2 max-pool sequencer: streams a square map from an input buffer, writes pooled map.
// Optional fused ReLU on the written value when MAXPOOL_CTRL_RELU_EN is defined.
module maxpool_ctrl #(
   parameter int unsigned IN_WIDTH = 28,
   parameter int unsigned DATA_W   = 32,
   localparam int unsigned OUT_WIDTH  = IN_WIDTH / 2,
   localparam int unsigned ADDR_W     = $clog2(IN_WIDTH * IN_WIDTH),
   localparam int unsigned OUT_ADDR_W = (OUT_WIDTH * OUT_WIDTH > 1) ? $clog2(OUT_WIDTH * OUT_WIDTH) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  rd_en,
   output logic [ADDR_W-1:0]     rd_addr,
   input  logic [DATA_W-1:0]     rd_data,
   output logic                  wr_en,
   output logic [OUT_ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0]     wr_data
);

   localparam int unsigned CNT_W = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;
   localparam logic [CNT_W-1:0]      OX_LAST = CNT_W'(OUT_WIDTH - 1);
   localparam logic [OUT_ADDR_W-1:0] W_LAST  = OUT_ADDR_W'(OUT_WIDTH * OUT_WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t                  state_q, state_d;
   logic                    busy_q, busy_d, done_q, done_d;
   logic                    rd_en_q, rd_en_d;
   logic [ADDR_W-1:0]       rd_addr_q, rd_addr_d;
   logic [1:0]              tap_q, tap_d, rd_tap_q, rd_tap_d, vld_tap_q, vld_tap_d;
   logic                    vld_q, vld_d;
   logic [CNT_W-1:0]        ox_q, ox_d, oy_q, oy_d;
   logic signed [DATA_W-1:0] acc_q, acc_d;
   logic [OUT_ADDR_W-1:0]   wcnt_q, wcnt_d;
   logic                    wr_en_q, wr_en_d;
   logic [OUT_ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0]       wr_data_q, wr_data_d;
   logic                    last_wr_q, last_wr_d;
   logic signed [DATA_W-1:0] din_c, max_c;

   // Next-state, read sequencing and reduction datapath
   always_comb begin
      state_d   = state_q;
      rd_en_d   = 1'b0;
      rd_addr_d = rd_addr_q;
      tap_d     = tap_q;
      rd_tap_d  = rd_tap_q;
      vld_d     = rd_en_q;
      vld_tap_d = rd_tap_q;
      ox_d      = ox_q;
      oy_d      = oy_q;
      acc_d     = acc_q;
      wcnt_d    = wcnt_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      last_wr_d = wr_en_q && (wr_addr_q == W_LAST);
      din_c     = $signed(rd_data);
      max_c     = (din_c > acc_q) ? din_c : acc_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RUN;
               tap_d   = 2'd0;
               ox_d    = '0;
               oy_d    = '0;
               wcnt_d  = '0;
            end
         end
         S_RUN: begin
            // {row, tap_y} * width + {col, tap_x} == (2*oy+ty)*W + 2*ox+tx
            rd_en_d   = 1'b1;
            rd_addr_d = ADDR_W'(ADDR_W'({oy_q, tap_q[1]}) * ADDR_W'(IN_WIDTH)
                        + ADDR_W'({ox_q, tap_q[0]}));
            rd_tap_d  = tap_q;
            tap_d     = tap_q + 2'd1;
            if (tap_q == 2'd3) begin
               if (ox_q == OX_LAST) begin
                  ox_d = '0;
                  if (oy_q == OX_LAST) begin
                     oy_d    = '0;
                     state_d = S_DRAIN;
                  end else begin
                     oy_d = oy_q + CNT_W'(1);
                  end
               end else begin
                  ox_d = ox_q + CNT_W'(1);
               end
            end
         end
         S_DRAIN: begin
            if (last_wr_q) state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Ties keep the earlier tap: only a strictly greater sample replaces the accumulator
      if (vld_q) begin
         acc_d = (vld_tap_q == 2'd0) ? din_c : max_c;
         if (vld_tap_q == 2'd3) begin
            wr_en_d   = 1'b1;
            wr_addr_d = wcnt_q;
            wcnt_d    = wcnt_q + OUT_ADDR_W'(1);
`ifdef MAXPOOL_CTRL_RELU_EN
            wr_data_d = max_c[DATA_W-1] ? '0 : max_c;
`else
            wr_data_d = max_c;
`endif
         end
      end

      busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         rd_en_q   <= 1'b0;
         rd_addr_q <= '0;
         tap_q     <= '0;
         rd_tap_q  <= '0;
         vld_q     <= 1'b0;
         vld_tap_q <= '0;
         ox_q      <= '0;
         oy_q      <= '0;
         acc_q     <= '0;
         wcnt_q    <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         last_wr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         rd_en_q   <= rd_en_d;
         rd_addr_q <= rd_addr_d;
         tap_q     <= tap_d;
         rd_tap_q  <= rd_tap_d;
         vld_q     <= vld_d;
         vld_tap_q <= vld_tap_d;
         ox_q      <= ox_d;
         oy_q      <= oy_d;
         acc_q     <= acc_d;
         wcnt_q    <= wcnt_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         last_wr_q <= last_wr_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign rd_en   = rd_en_q;
   assign rd_addr = rd_addr_q;
   assign wr_en   = wr_en_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;

endmodule

// File: tb/tb_maxpool_ctrl.sv
// Bench for maxpool_ctrl: a 4x4 and a 28x28 instance against a 2x2-max reference over bench memories.
module tb_maxpool_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n = 1'b0;
   logic start_v = 1'b0;
   logic sel_big = 1'b0;

   logic start4, start28;
   assign start4  = !sel_big && start_v;
   assign start28 = sel_big && start_v;

   logic        busy4, done4, rd_en4, wr_en4;
   logic [3:0]  rd_addr4;
   logic [1:0]  wr_addr4;
   logic [31:0] rd_data4 = '0, wr_data4;
   logic        busy28, done28, rd_en28, wr_en28;
   logic [9:0]  rd_addr28;
   logic [7:0]  wr_addr28;
   logic [31:0] rd_data28 = '0, wr_data28;

   maxpool_ctrl #(.IN_WIDTH(4), .DATA_W(32)) u4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .busy(busy4), .done(done4),
      .rd_en(rd_en4), .rd_addr(rd_addr4), .rd_data(rd_data4),
      .wr_en(wr_en4), .wr_addr(wr_addr4), .wr_data(wr_data4));

   maxpool_ctrl #(.IN_WIDTH(28), .DATA_W(32)) u28 (
      .clk(clk), .rst_n(rst_n), .start(start28), .busy(busy28), .done(done28),
      .rd_en(rd_en28), .rd_addr(rd_addr28), .rd_data(rd_data28),
      .wr_en(wr_en28), .wr_addr(wr_addr28), .wr_data(wr_data28));

   logic signed [31:0] mem4 [16];
   logic signed [31:0] mem28 [784];

   // Input buffers: data valid the cycle after the strobe
   always @(posedge clk) begin
      if (rd_en4)  rd_data4  <= mem4[rd_addr4];
      if (rd_en28) rd_data28 <= mem28[rd_addr28];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Selected-DUT view
   logic m_busy, m_done, m_rd_en, m_wr_en;
   int   m_rd_addr, m_wr_addr;
   logic signed [31:0] m_wr_data;
   assign m_busy    = sel_big ? busy28  : busy4;
   assign m_done    = sel_big ? done28  : done4;
   assign m_rd_en   = sel_big ? rd_en28 : rd_en4;
   assign m_wr_en   = sel_big ? wr_en28 : wr_en4;
   assign m_rd_addr = sel_big ? int'(rd_addr28) : int'(rd_addr4);
   assign m_wr_addr = sel_big ? int'(wr_addr28) : int'(wr_addr4);
   assign m_wr_data = sel_big ? wr_data28 : wr_data4;

   int n_chk = 0, n_pass = 0;
   task automatic chk(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   // Monitor: log writes, done pulses, read sequence and busy length relative to acceptance edge
   bit mon_on = 1'b0;
   int t0 = 0, mon_n = 4;
   int waq[$], wcq[$], dq[$];
   logic signed [31:0] wdq[$];
   int rd_cnt, rd_bad, busy_cnt;
   always @(negedge clk) begin
      if (mon_on) begin
         int rel, k, o, ea;
         rel = cyc - t0;
         o   = mon_n / 2;
         if (m_wr_en) begin
            waq.push_back(m_wr_addr);
            wcq.push_back(rel);
            wdq.push_back(m_wr_data);
         end
         if (m_done) dq.push_back(rel);
         if (m_busy) busy_cnt++;
         if (m_rd_en) begin
            rd_cnt++;
            k  = rel - 1;
            ea = (2 * ((k / 4) / o) + (k % 4) / 2) * mon_n + 2 * ((k / 4) % o) + (k % 4) % 2;
            if (m_rd_addr != ea) rd_bad++;
         end
      end
   end

   function automatic logic signed [31:0] ref_pool(input bit big, input int n);
      int nn, o, x, y;
      logic signed [31:0] best, v;
      nn = big ? 28 : 4;
      o  = nn / 2;
      x  = 2 * (n % o);
      y  = 2 * (n / o);
      best = big ? mem28[y*nn + x] : mem4[y*nn + x];
      for (int dy = 0; dy < 2; dy++)
         for (int dx = 0; dx < 2; dx++) begin
            v = big ? mem28[(y+dy)*nn + x+dx] : mem4[(y+dy)*nn + x+dx];
            if (v > best) best = v;
         end
`ifdef MAXPOOL_CTRL_RELU_EN
      if (best < 0) best = 0;
`endif
      return best;
   endfunction

   // One run: start sampled at edge 0; extra start pulses in cycles sa/sb; reset sampled at edge rst_at
   task automatic do_run(input bit big, input int sa, input int sb, input int rst_at, input int ncyc);
      int nn, w, exp_w;
      nn = big ? 28 : 4;
      w  = (nn / 2) * (nn / 2);
      sel_big = big;
      mon_n   = nn;
      waq.delete(); wcq.delete(); wdq.delete(); dq.delete();
      rd_cnt = 0; rd_bad = 0; busy_cnt = 0;
      start_v = 1'b1;
      @(posedge clk); #1;
      t0 = cyc;
      mon_on = 1'b1;
      for (int rel = 0; rel <= ncyc; rel++) begin
         if (rst_at > 0 && rel == rst_at) begin
            chk("rst_busy", m_busy, 0);
            chk("rst_done", m_done, 0);
            chk("rst_rd_en", m_rd_en, 0);
            chk("rst_wr_en", m_wr_en, 0);
            chk("rst_rd_addr", m_rd_addr, 0);
            chk("rst_wr_addr", m_wr_addr, 0);
            chk("rst_wr_data", m_wr_data, 0);
         end
         start_v = (rel == sa) || (rel == sb);
         rst_n   = !(rst_at > 0 && rel + 1 == rst_at);
         @(posedge clk); #1;
      end
      start_v = 1'b0;
      rst_n   = 1'b1;
      mon_on  = 1'b0;

      exp_w = w;
      if (rst_at > 0) begin
         exp_w = 0;
         for (int n = 0; n < w; n++) if (6 + 4*n < rst_at) exp_w++;
      end
      chk("wr_count", waq.size(), exp_w);
      for (int i = 0; i < waq.size() && i < exp_w; i++) begin
         chk("wr_addr", waq[i], i);
         chk("wr_cycle", wcq[i], 6 + 4*i);
         chk("wr_data", wdq[i], ref_pool(big, i));
      end
      chk("rd_seq_bad", rd_bad, 0);
      if (rst_at > 0) begin
         chk("abort_done_cnt", dq.size(), 0);
      end else begin
         chk("done_cnt", dq.size(), 1);
         if (dq.size() > 0) chk("done_cycle", dq[0], 4*w + 4);
         chk("rd_cnt", rd_cnt, 4*w);
         chk("busy_len", busy_cnt, 4*w + 4);
         chk("hold_rd_addr", m_rd_addr, nn*nn - 1);
         chk("hold_wr_addr", m_wr_addr, w - 1);
         chk("hold_wr_data", m_wr_data, ref_pool(big, w - 1));
      end
   endtask

   typedef struct {
      logic signed [31:0] w [4];
      logic signed [31:0] exp_raw;
      logic signed [31:0] exp_relu;
   } vec_t;
   vec_t tbl [6];

   initial begin
      logic signed [31:0] e;
      tbl[0].w = '{-5, -2, -9, -2};  tbl[0].exp_raw = -2;  tbl[0].exp_relu = 0;
      tbl[1].w = '{1, 2, 3, 4};      tbl[1].exp_raw = 4;   tbl[1].exp_relu = 4;
      tbl[2].w = '{4, 3, 2, 1};      tbl[2].exp_raw = 4;   tbl[2].exp_relu = 4;
      tbl[3].w = '{3, 9, 9, 1};      tbl[3].exp_raw = 9;   tbl[3].exp_relu = 9;
      tbl[4].w = '{32'sh80000000, 32'sh80000000, 32'sh80000000, 32'sh80000000};
      tbl[4].exp_raw = 32'sh80000000; tbl[4].exp_relu = 0;
      tbl[5].w = '{-1, -1, 0, -1};   tbl[5].exp_raw = 0;   tbl[5].exp_relu = 0;

      for (int i = 0; i < 16; i++) mem4[i] = 32'(i);
      for (int i = 0; i < 784; i++) mem28[i] = '0;

      // Reset state of both instances
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", busy4 | busy28, 0);
      chk("reset_done", done4 | done28, 0);
      chk("reset_rd_en", rd_en4 | rd_en28, 0);
      chk("reset_wr_en", wr_en4 | wr_en28, 0);
      chk("reset_rd_addr", rd_addr4 | 4'(rd_addr28), 0);
      chk("reset_wr_data", wr_data4 | wr_data28, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Ramp map: pooled 5,7,13,15 at cycles 6,10,14,18, done at 20
      do_run(1'b0, -1, -1, 0, 20);
      if (wdq.size() == 4) begin
         chk("ramp_w0", wdq[0], 5);
         chk("ramp_w1", wdq[1], 7);
         chk("ramp_w2", wdq[2], 13);
         chk("ramp_w3", wdq[3], 15);
      end else begin
         chk("ramp_nwr", wdq.size(), 4);
      end

      // Window-0 value table, back-to-back runs
      for (int t = 0; t < 6; t++) begin
         for (int i = 0; i < 16; i++) mem4[i] = 32'(i);
         mem4[0] = tbl[t].w[0]; mem4[1] = tbl[t].w[1];
         mem4[4] = tbl[t].w[2]; mem4[5] = tbl[t].w[3];
`ifdef MAXPOOL_CTRL_RELU_EN
         e = tbl[t].exp_relu;
`else
         e = tbl[t].exp_raw;
`endif
         do_run(1'b0, -1, -1, 0, 20);
         if (wdq.size() > 0) chk("tbl_w0", wdq[0], e);
         else chk("tbl_w0_missing", 0, 1);
      end

      // Start while busy and during the done cycle is ignored
      for (int i = 0; i < 16; i++) mem4[i] = 32'(15 - i);
      do_run(1'b0, 5, 20, 0, 22);

      // Reset sampled at edge 9 aborts; then a clean run
      do_run(1'b0, -1, -1, 9, 30);
      do_run(1'b0, -1, -1, 0, 20);

      // Random small maps with frequent ties and negatives
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 16; i++) mem4[i] = 32'(int'($urandom_range(0, 20)) - 10);
         do_run(1'b0, -1, -1, 0, 20);
      end

      // Full-size random map
      for (int i = 0; i < 784; i++) mem28[i] = $urandom;
      do_run(1'b1, -1, -1, 0, 4*196 + 4);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
